if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry IF stage.
- Drives a synchronous 1-cycle-latency instruction SRAM from a PC register and buffers returned instructions, each tagged with its PC, in a FQ_DEPTH-entry fetch queue.
- Presents instructions to the OF stage over a valid/ready handshake.
- A branch redirect from EX flushes the queue and kills any in-flight SRAM response.

Parameters:
- XLEN, 32, PC and instruction width in bits.
- INST_ADDR_WIDTH, 10, instruction SRAM word-address width.
- FQ_DEPTH, 4, fetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  in  1  single clock, all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  run enable; low stops new fetches, queue still drains.
- Imem_En  out  1  SRAM read strobe.
- Imem_Addr  out  INST_ADDR_WIDTH  word address, equal to pc[INST_ADDR_WIDTH+1:2].
- Imem_Data  in  XLEN  read data, valid the cycle after Imem_En.
- Ex_IsBranchTaken  in  1  redirect request, one-cycle pulse.
- Ex_BranchPC  in  XLEN  redirect target; bits [1:0] ignored and treated as 00.
- Of_Valid  out  1  queue head valid.
- Of_Ready  in  1  OF stage accepts the head.
- Of_Pc  out  XLEN  PC of the head entry.
- Of_Instr  out  XLEN  instruction of the head entry.
- Fq_Count  out  $clog2(FQ_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (asynchronous, Rst_n=0):
  - pc = RESET_PC.
  - Queue empty, rd/wr pointers = 0, Fq_Count = 0, in-flight flag = 0.
  - Imem_En = 0, Of_Valid = 0, Of_Pc = 0, Of_Instr = 0.
  - Reset asserted mid-operation discards all queued and in-flight entries immediately.
- Control FSM, two states:
  - IDLE: no fetches. Go to RUN when Start=1.
  - RUN: fetch. Go to IDLE when Start=0. The in-flight response still lands and the queue still drains.
- Credit rule: a fetch is issued (Imem_En=1, combinational) only when all of the following hold:
  - state is RUN;
  - Ex_IsBranchTaken=0;
  - Fq_Count + inflight - pop < FQ_DEPTH, where pop = Of_Valid & Of_Ready.
  - This guarantees no push ever reaches a full queue.
- On issue:
  - pc <= pc + 4, wrapping modulo 2^XLEN.
  - An in-flight register captures the issued pc and sets the in-flight flag.
  - If no fetch is issued, pc holds.
- Response: the cycle after issue, {inflight_pc, Imem_Data} is pushed at the tail unless it was killed.
- Of_Valid = (Fq_Count != 0) & ~Ex_IsBranchTaken. Of_Pc and Of_Instr come from the head entry.
- Pop on Of_Valid & Of_Ready.
  - Simultaneous push and pop leaves Fq_Count unchanged, including when the queue is full.
  - Pop from an empty queue cannot occur.
- Latency: Start rising in cycle 0 gives Imem_En in cycle 0 and the push at the end of cycle 1. Of_Valid rises in cycle 2. There is no bypass in the base build.
- Redirect (Ex_IsBranchTaken=1) has priority over everything else:
  - Queue cleared; a pop in that cycle does not occur because Of_Valid is forced 0.
  - The current in-flight response is killed and never pushed.
  - pc <= {Ex_BranchPC[XLEN-1:2], 2'b00}, and no fetch is issued that cycle.
  - The target is fetched the next cycle if state is RUN.
- Back-to-back redirects: the last one wins.
- A redirect arriving in IDLE still loads pc and flushes.
- Holding the output:
  - Of_Valid stays high and the head stays stable until accepted or flushed.
  - The OF stage may hold Of_Ready low indefinitely; fetching stops when credits run out.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds two outputs:
  - Perf_Fetch_Cnt (32b): increments on every non-killed push.
  - Perf_Stall_Cnt (32b): increments each cycle with Of_Valid=1 and Of_Ready=0.
  - Both counters reset to 0, wrap at 2^32, and are not cleared by a redirect.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset then Start=1, Of_Ready=1, IMEM word n = 0x1000_0000+n → Of_Valid first rises in cycle 2. Handshakes deliver PC 0x0,0x4,0x8,… with instr 0x1000_0000,0x1000_0001,…, one per cycle.
- Of_Ready=0 for 10 cycles, FQ_DEPTH=4 → Fq_Count saturates at 4, Imem_En=0 after credits are exhausted, head stays PC 0x0. Releasing Of_Ready delivers 0x0..0xC in order with no loss or duplication.
- Redirect to 0x0000_0103 while the queue holds 3 entries and one fetch is in flight → next cycle Fq_Count=0 and Imem_Addr=0x40. The killed response is not seen, and the first delivered PC is 0x100.
- Start dropped with 2 entries queued and 1 in flight → 3 entries delivered, then Of_Valid=0, Imem_En stays 0, pc frozen.
- Rst_n asserted mid-stream with queue full → outputs and Fq_Count go to 0 asynchronously, and PC restarts at RESET_PC after release.
- With IF_PERF_CNT_EN: 8 delivered instructions and 5 back-pressured cycles → Perf_Fetch_Cnt=8, Perf_Stall_Cnt=5. Killed fetches are not counted.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with a FQ_DEPTH-entry fetch queue.
// Drives a 1-cycle-latency instruction SRAM from a PC register, tags each
// returned word with its PC and hands entries to OF over valid/ready.
// A taken branch from EX flushes the queue and kills the in-flight read.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/stall performance counters.
module if_fetch_queue #(
    parameter int              XLEN            = 32,
    parameter int              INST_ADDR_WIDTH = 10,
    parameter int              FQ_DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Start,
    output logic                       Imem_En,
    output logic [INST_ADDR_WIDTH-1:0] Imem_Addr,
    input  logic [XLEN-1:0]            Imem_Data,
    input  logic                       Ex_IsBranchTaken,
    input  logic [XLEN-1:0]            Ex_BranchPC,
    output logic                       Of_Valid,
    input  logic                       Of_Ready,
    output logic [XLEN-1:0]            Of_Pc,
    output logic [XLEN-1:0]            Of_Instr,
    output logic [$clog2(FQ_DEPTH):0]  Fq_Count
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                Perf_Fetch_Cnt,
    output logic [31:0]                Perf_Stall_Cnt
`endif
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = CW + 1;   // headroom for count + inflight

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e             state_q, state_d;
    logic               run_en;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    ipc_q;
    logic               inflight_q;
    logic [AW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [XLEN-1:0]    pc_mem_q    [FQ_DEPTH];
    logic [XLEN-1:0]    instr_mem_q [FQ_DEPTH];
    logic               issue, push, pop, credit_ok;
    logic [NW-1:0]      need;
    logic               unused_bpc_lsb;

    // Branch target low bits are forced to zero, so they are never consumed.
    assign unused_bpc_lsb = ^Ex_BranchPC[1:0];

    // Run-control FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; fetching follows the decision made this cycle so a Start
    // rise fetches immediately and a Start drop stops fetching immediately.
    always_comb begin
        state_d = state_q;
        run_en  = 1'b0;
        case (state_q)
            IDLE: if (Start) begin
                state_d = RUN;
                run_en  = 1'b1;
            end
            RUN: begin
                if (!Start) state_d = IDLE;
                else        run_en  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake, credit and push decisions.
    always_comb begin
        Of_Valid  = (count_q != '0) & ~Ex_IsBranchTaken;
        pop       = Of_Valid & Of_Ready;
        push      = inflight_q & ~Ex_IsBranchTaken;
        // Occupancy after this cycle's pop plus the outstanding response
        // must leave room for one more entry; count+inflight >= pop always.
        need      = NW'(count_q) + NW'(inflight_q) - NW'(pop);
        credit_ok = need < NW'(FQ_DEPTH);
        // Rst_n gates the strobe so no read fires while held in reset.
        issue     = Rst_n & run_en & ~Ex_IsBranchTaken & credit_ok;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    assign Imem_En   = issue;
    assign Imem_Addr = pc_q[INST_ADDR_WIDTH+1:2];
    assign Of_Pc     = pc_mem_q[rd_ptr_q];
    assign Of_Instr  = instr_mem_q[rd_ptr_q];
    assign Fq_Count  = count_q;

    // Next PC: redirect wins, otherwise advance only on issue.
    always_comb begin
        pc_d = pc_q;
        if (Ex_IsBranchTaken) pc_d = {Ex_BranchPC[XLEN-1:2], 2'b00};
        else if (issue)       pc_d = pc_q + XLEN'(4);
    end

    // PC and in-flight tracking; a redirect drops the outstanding response.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q       <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) ipc_q <= pc_q;
        end
    end

    // Fetch queue storage and pointers; a redirect empties it in one cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (Ex_IsBranchTaken) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= ipc_q;
                instr_mem_q[wr_ptr_q] <= Imem_Data;
                wr_ptr_q              <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Performance counters; free-running, survive redirects, wrap at 2^32.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push)                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (Of_Valid & ~Of_Ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign Perf_Fetch_Cnt = fetch_cnt_q;
    assign Perf_Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue. IMEM word n holds 0x1000_0000+n.
// Inputs change 2 time units after each rising edge; outputs are read after.
module tb_if_fetch_queue;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        Imem_En;
    logic [9:0]  Imem_Addr;
    logic [31:0] Imem_Data = 32'h0;
    logic        Ex_IsBranchTaken = 1'b0;
    logic [31:0] Ex_BranchPC = 32'h0;
    logic        Of_Valid;
    logic        Of_Ready = 1'b0;
    logic [31:0] Of_Pc;
    logic [31:0] Of_Instr;
    logic [2:0]  Fq_Count;
`ifdef IF_PERF_CNT_EN
    logic [31:0] Perf_Fetch_Cnt, Perf_Stall_Cnt;
`endif

    int tests = 0;
    int fails = 0;

    if_fetch_queue dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .Imem_En(Imem_En), .Imem_Addr(Imem_Addr), .Imem_Data(Imem_Data),
        .Ex_IsBranchTaken(Ex_IsBranchTaken), .Ex_BranchPC(Ex_BranchPC),
        .Of_Valid(Of_Valid), .Of_Ready(Of_Ready), .Of_Pc(Of_Pc),
        .Of_Instr(Of_Instr), .Fq_Count(Fq_Count)
`ifdef IF_PERF_CNT_EN
        , .Perf_Fetch_Cnt(Perf_Fetch_Cnt), .Perf_Stall_Cnt(Perf_Stall_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Synchronous SRAM model, one-cycle read latency.
    always @(posedge Clk) if (Imem_En) Imem_Data <= 32'h1000_0000 + 32'(Imem_Addr);

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; Start = 1'b0; Of_Ready = 1'b0;
        Ex_IsBranchTaken = 1'b0; Ex_BranchPC = 32'h0;
        tick(); tick();
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Start = 1'b1; Of_Ready = 1'b1;
        tick(); tick(); #1;
        tests++; if (Imem_En !== 1'b0) begin fails++; $display("FAIL reset_en got %0h exp 0", Imem_En); end
        tests++; if (Of_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h exp 0", Of_Valid); end
        tests++; if (Of_Pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", Of_Pc); end
        tests++; if (Of_Instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", Of_Instr); end
        tests++; if (Fq_Count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", Fq_Count); end
        tests++; if (Imem_Addr !== 10'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", Imem_Addr); end
    endtask

    task automatic test_stream();
        do_reset();
        tick(); Start = 1'b1; Of_Ready = 1'b1; #1;
        tests++; if (Imem_En !== 1'b1) begin fails++; $display("FAIL lat_en_c0 got %0h exp 1", Imem_En); end
        tests++; if (Of_Valid !== 1'b0) begin fails++; $display("FAIL lat_valid_c0 got %0h exp 0", Of_Valid); end
        tick();
        tests++; if (Of_Valid !== 1'b0) begin fails++; $display("FAIL lat_valid_c1 got %0h exp 0", Of_Valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if ({Of_Valid, Of_Pc, Of_Instr, Fq_Count} !== {1'b1, 32'(4*k), 32'h1000_0000 + 32'(k), 3'd1}) begin
                fails++;
                $display("FAIL stream_%0d got v=%0h pc=%h in=%h cnt=%0d exp v=1 pc=%h in=%h cnt=1",
                         k, Of_Valid, Of_Pc, Of_Instr, Fq_Count, 32'(4*k), 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(); Start = 1'b1; Of_Ready = 1'b0; #1;
        for (int c = 1; c < 10; c++) begin
            tick();
            if (c >= 2) begin
                tests++;
                if ({Of_Valid, Of_Pc} !== {1'b1, 32'h0}) begin
                    fails++; $display("FAIL bp_head_c%0d got v=%0h pc=%h exp v=1 pc=0", c, Of_Valid, Of_Pc);
                end
            end
            if (c >= 4) begin
                tests++;
                if (Imem_En !== 1'b0) begin fails++; $display("FAIL bp_en_c%0d got %0h exp 0", c, Imem_En); end
            end
        end
        tests++; if (Fq_Count !== 3'd4) begin fails++; $display("FAIL bp_count got %0d exp 4", Fq_Count); end
        tick(); Of_Ready = 1'b1; #1;
        for (int j = 0; j < 6; j++) begin
            tests++;
            if ({Of_Valid, Of_Pc, Of_Instr} !== {1'b1, 32'(4*j), 32'h1000_0000 + 32'(j)}) begin
                fails++;
                $display("FAIL bp_drain_%0d got v=%0h pc=%h in=%h exp pc=%h", j, Of_Valid, Of_Pc, Of_Instr, 32'(4*j));
            end
            if (j < 5) tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); Start = 1'b1; Of_Ready = 1'b0;
        tick(); tick(); tick(); tick();
        tests++; if (Fq_Count !== 3'd3) begin fails++; $display("FAIL rd_pre_count got %0d exp 3", Fq_Count); end
        Ex_IsBranchTaken = 1'b1; Ex_BranchPC = 32'h0000_0103; #1;
        tests++; if (Of_Valid !== 1'b0) begin fails++; $display("FAIL rd_valid got %0h exp 0", Of_Valid); end
        tests++; if (Imem_En !== 1'b0) begin fails++; $display("FAIL rd_en got %0h exp 0", Imem_En); end
        tick(); Ex_IsBranchTaken = 1'b0; Of_Ready = 1'b1; #1;
        tests++; if (Fq_Count !== 3'd0) begin fails++; $display("FAIL rd_count got %0d exp 0", Fq_Count); end
        tests++; if (Imem_Addr !== 10'h040) begin fails++; $display("FAIL rd_addr got %h exp 040", Imem_Addr); end
        tests++; if (Imem_En !== 1'b1) begin fails++; $display("FAIL rd_en_next got %0h exp 1", Imem_En); end
        tick();
        tests++; if (Of_Valid !== 1'b0) begin fails++; $display("FAIL rd_killed got %0h exp 0", Of_Valid); end
        tick();
        tests++;
        if ({Of_Valid, Of_Pc, Of_Instr} !== {1'b1, 32'h100, 32'h1000_0040}) begin
            fails++; $display("FAIL rd_first got v=%0h pc=%h in=%h exp pc=100 in=10000040", Of_Valid, Of_Pc, Of_Instr);
        end
        tick();
        tests++; if (Of_Pc !== 32'h104) begin fails++; $display("FAIL rd_second got %h exp 104", Of_Pc); end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        tick(); Ex_IsBranchTaken = 1'b1; Ex_BranchPC = 32'h0000_02FC; #1;
        tests++; if (Imem_En !== 1'b0) begin fails++; $display("FAIL ri_en got %0h exp 0", Imem_En); end
        tick(); Ex_BranchPC = 32'h0000_0301;
        tick(); Ex_IsBranchTaken = 1'b0; Start = 1'b1; #1;
        tests++; if (Imem_Addr !== 10'h0C0) begin fails++; $display("FAIL ri_addr got %h exp 0c0", Imem_Addr); end
        tests++; if (Imem_En !== 1'b1) begin fails++; $display("FAIL ri_en_run got %0h exp 1", Imem_En); end
        tick(); tick();
        tests++;
        if ({Of_Valid, Of_Pc, Of_Instr} !== {1'b1, 32'h300, 32'h1000_00C0}) begin
            fails++; $display("FAIL ri_first got v=%0h pc=%h in=%h exp pc=300 in=100000c0", Of_Valid, Of_Pc, Of_Instr);
        end
    endtask

    task automatic test_start_drop();
        do_reset();
        tick(); Start = 1'b1; Of_Ready = 1'b0;
        tick(); tick();
        tick(); Start = 1'b0; #1;
        tests++; if (Imem_En !== 1'b0) begin fails++; $display("FAIL sd_en got %0h exp 0", Imem_En); end
        tick(); Of_Ready = 1'b1; #1;
        tests++; if (Fq_Count !== 3'd3) begin fails++; $display("FAIL sd_count got %0d exp 3", Fq_Count); end
        for (int j = 0; j < 3; j++) begin
            tests++;
            if ({Of_Valid, Of_Pc} !== {1'b1, 32'(4*j)}) begin
                fails++; $display("FAIL sd_drain_%0d got v=%0h pc=%h exp pc=%h", j, Of_Valid, Of_Pc, 32'(4*j));
            end
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            tests++;
            if ({Of_Valid, Imem_En, Imem_Addr} !== {1'b0, 1'b0, 10'h003}) begin
                fails++; $display("FAIL sd_idle_%0d got v=%0h en=%0h addr=%h exp 0 0 003", j, Of_Valid, Imem_En, Imem_Addr);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(); Start = 1'b1; Of_Ready = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        tests++; if (Fq_Count !== 3'd4) begin fails++; $display("FAIL rm_full got %0d exp 4", Fq_Count); end
        #1 Rst_n = 1'b0; #1;
        tests++;
        if ({Fq_Count, Of_Valid, Of_Pc, Of_Instr, Imem_En} !== {3'd0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            fails++; $display("FAIL rm_async got cnt=%0d v=%0h pc=%h in=%h en=%0h exp all 0",
                              Fq_Count, Of_Valid, Of_Pc, Of_Instr, Imem_En);
        end
        tick(); Rst_n = 1'b1; #1;
        tests++;
        if ({Imem_En, Imem_Addr} !== {1'b1, 10'h000}) begin
            fails++; $display("FAIL rm_restart got en=%0h addr=%h exp 1 000", Imem_En, Imem_Addr);
        end
        tick();
        tests++; if (Imem_Addr !== 10'h001) begin fails++; $display("FAIL rm_next got %h exp 001", Imem_Addr); end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        tick(); Start = 1'b1; Of_Ready = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        Start = 1'b0; Of_Ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        Start = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        Start = 1'b0;
        tick(); Start = 1'b1;
        tick(); Start = 1'b0; Ex_IsBranchTaken = 1'b1;
        tick(); Ex_IsBranchTaken = 1'b0;
        tick(); tick(); tick(); #1;
        tests++; if (Perf_Fetch_Cnt !== 32'd8) begin fails++; $display("FAIL perf_fetch got %0d exp 8", Perf_Fetch_Cnt); end
        tests++; if (Perf_Stall_Cnt !== 32'd5) begin fails++; $display("FAIL perf_stall got %0d exp 5", Perf_Stall_Cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_idle();
        test_start_drop();
        test_reset_mid();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
